second_digit_ctrl: RTL
======================

# second_digit_ctrl

Run/pause/clear controller for the seconds counter and single-digit 7-segment display path of the top-level design. Divides the system clock (10 MHz on board) into a one-second tick, advances a digit register on each tick with wrap-around, and drives the segment pattern. Sits between the user-input decode (`ui_in` switches) and the `uo_out` display pins.

## Interface
- `CLK_HZ`, 10_000_000, input clock frequency.
- `TICK_HZ`, 1, tick rate. `DIV = CLK_HZ/TICK_HZ`; must be ≥ 2.
- `MAX_DIGIT`, 9, last digit value before wrap; range 1..15.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start_i` in 1: enter RUN, level-sampled each cycle.
- `stop_i` in 1: RUN→PAUSE.
- `clear_i` in 1: digit and prescaler to 0, go IDLE.
- `load_i` in 1: write `load_val_i` into digit.
- `load_val_i` in 4: load value.
- `dir_i` in 1: count direction, 1 = down. Present only with `DOWN_COUNT_EN`.
- `tick_o` out 1: one-cycle tick pulse.
- `wrap_o` out 1: one-cycle pulse, coincident with the `tick_o` that wraps the digit.
- `digit_o` out 4: current digit.
- `seg_o` out 7: active-high segments, bit order {g,f,e,d,c,b,a}.
- `state_o` out 2: IDLE=0, RUN=1, PAUSE=2.

## Operation
- Reset values: state IDLE, prescaler 0, `digit_o` 0, `tick_o` 0, `wrap_o` 0, `seg_o` 7'h3F, `state_o` 0.
- Command priority per cycle: clear > load > stop > start.
- IDLE: prescaler held at 0. `start_i` → RUN. `stop_i` is ignored.
- RUN: prescaler increments 0..DIV-1 and wraps to 0.
  - When prescaler = DIV-1: `tick_o`=1, and the digit advances on that edge.
  - Up count: at MAX_DIGIT the digit goes to 0 and `wrap_o`=1.
  - `stop_i` → PAUSE. The prescaler does not increment on the stop edge, and no tick is issued that cycle.
- PAUSE: prescaler and digit frozen. `start_i` → RUN, resuming from the frozen prescaler value.
- clear (any state): prescaler 0, digit 0, state IDLE. Pulses suppressed that cycle.
- load (any state): digit ← min(`load_val_i`, MAX_DIGIT), prescaler ← 0, state unchanged. The tick is suppressed that cycle.
- `seg_o`: combinational decode of registered `digit_o`.
  - 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - A..F: 77 7C 39 5E 79 71.
- `reset` asserted mid-operation: all outputs reach their reset values after the next edge.

## Timing
- `start_i` in cycle 0 from IDLE: RUN with prescaler 0 in cycle 1. `tick_o` high in cycle DIV. New digit visible in cycle DIV+1.
- Tick period: exactly DIV cycles while in RUN.
- `tick_o` and `wrap_o` are registered-state decodes with no extra latency. `seg_o` tracks `digit_o` in the same cycle.
- Prescaler width: `$clog2(DIV)`. Comparisons are made against DIV-1 at that width.

## Configuration
- `DOWN_COUNT_EN` defined:
  - `dir_i` port exists.
  - `dir_i`=1 decrements on tick; at 0 the digit goes to MAX_DIGIT and `wrap_o`=1.
  - `dir_i` is sampled on the tick edge.
- `DOWN_COUNT_EN` undefined: no `dir_i` port; up-count only.

## Structure
- Shared package `second_digit_pkg`:
  - state enum (IDLE/RUN/PAUSE).
  - the 16-entry segment constant table.
  - digit width constant (4).
- One sub-module, `seg7_decode`: combinational digit→segments. The controller instantiates it.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10) and MAX_DIGIT=9.
- Reset, then `start_i` in cycle 0 → `tick_o` high only in cycle 10; `digit_o`=1 and `seg_o`=06 in cycle 11.
- Run for 10 ticks → on the 10th tick `wrap_o` and `tick_o` are both high; `digit_o` goes 9→0 and `seg_o`=3F.
- `stop_i` while prescaler=4, hold 20 cycles, then `start_i` in cycle t → no tick while paused; next `tick_o` in cycle t+6.
- `load_i` with `load_val_i`=12 → `digit_o`=9. Then `load_i` with 7 → `digit_o`=7, `seg_o`=07, prescaler=0.
- `clear_i` and `start_i` in the same cycle during RUN → state IDLE, `digit_o`=0, no tick thereafter.
- With `DOWN_COUNT_EN`: `dir_i`=1, start from digit 0 → first tick gives `digit_o`=9 with `wrap_o`=1.

Source files
------------

// File: rtl/second_digit_pkg.sv
// -----------------------------------------------------------------------------
// second_digit_pkg
// Shared definitions for the seconds-digit controller:
//   - state_e   : controller state encoding (IDLE=0, RUN=1, PAUSE=2)
//   - DIGIT_W   : width of the displayed digit
//   - SEG_TABLE : 16-entry active-high segment table, bit order {g,f,e,d,c,b,a}
//   - seg_lookup: digit -> segment pattern helper
// -----------------------------------------------------------------------------
package second_digit_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Entry 0 is the rightmost element; hex digits A..F share the table.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77,                 // F..A
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B,   // 9..2
        7'h06, 7'h3F                                              // 1..0
    };

    function automatic logic [6:0] seg_lookup(input logic [DIGIT_W-1:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/second_digit_ctrl_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational digit -> 7-segment decode.
// Ports:
//   digit  in  4 : digit value 0..15
//   seg    out 7 : active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_decode
    import second_digit_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    // Table lookup; every 4-bit value has a defined pattern.
    always_comb begin
        seg = seg_lookup(digit);
    end

endmodule

// File: rtl/second_digit_ctrl.sv
// -----------------------------------------------------------------------------
// second_digit_ctrl
// Run/pause/clear controller for a one-digit seconds display. A prescaler
// divides clk by DIV = CLK_HZ/TICK_HZ; each tick advances the digit, which
// wraps after MAX_DIGIT. The digit is decoded to 7-segment drive.
//
// Optional feature: define DOWN_COUNT_EN to add dir_i (1 = count down,
// wrapping from 0 to MAX_DIGIT). Without it the block counts up only.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start_i         : enter RUN (from IDLE or PAUSE)
//   stop_i          : RUN -> PAUSE
//   clear_i         : digit/prescaler to 0, go IDLE (highest priority)
//   load_i          : digit <= min(load_val_i, MAX_DIGIT), prescaler <= 0
//   load_val_i [4]  : load value
//   dir_i           : count direction (only with DOWN_COUNT_EN)
//   tick_o          : one-cycle tick pulse
//   wrap_o          : one-cycle pulse on the tick that wraps the digit
//   digit_o [4]     : current digit
//   seg_o   [7]     : segments {g,f,e,d,c,b,a}, active high
//   state_o [2]     : IDLE=0, RUN=1, PAUSE=2
// -----------------------------------------------------------------------------
module second_digit_ctrl
    import second_digit_pkg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int TICK_HZ   = 1,
    parameter int MAX_DIGIT = 9
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_val_i,
`ifdef DOWN_COUNT_EN
    input  logic               dir_i,
`endif
    output logic               tick_o,
    output logic               wrap_o,
    output logic [DIGIT_W-1:0] digit_o,
    output logic [6:0]         seg_o,
    output logic [1:0]         state_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(MAX_DIGIT);

    state_e               state_r;
    logic [PW-1:0]        presc_r;
    logic [DIGIT_W-1:0]   digit_r;

    logic                 down_s;
    logic                 at_last_s;
    logic                 tick_s;
    logic                 edge_s;
    logic [DIGIT_W-1:0]   digit_next_s;
    logic [DIGIT_W-1:0]   load_clamp_s;

    // Count direction: dir_i only matters on the tick edge, where it is used.
`ifdef DOWN_COUNT_EN
    always_comb begin
        down_s = dir_i;
    end
`else
    always_comb begin
        down_s = 1'b0;
    end
`endif

    // Tick decode: last prescaler count in RUN, suppressed by any command
    // that pre-empts counting on this edge (clear, load, stop).
    always_comb begin
        at_last_s = (state_r == RUN) && (presc_r == PRESC_LAST);
        tick_s    = at_last_s && !clear_i && !load_i && !stop_i;
    end

    // Next digit on a tick and whether that step wraps.
    always_comb begin
        if (down_s) begin
            edge_s = (digit_r == {DIGIT_W{1'b0}});
            if (edge_s) begin
                digit_next_s = DIGIT_LAST;
            end else begin
                digit_next_s = digit_r - DIGIT_W'(1);
            end
        end else begin
            edge_s = (digit_r >= DIGIT_LAST);
            if (edge_s) begin
                digit_next_s = {DIGIT_W{1'b0}};
            end else begin
                digit_next_s = digit_r + DIGIT_W'(1);
            end
        end
    end

    // Load value saturates at MAX_DIGIT.
    always_comb begin
        if (load_val_i > DIGIT_LAST) begin
            load_clamp_s = DIGIT_LAST;
        end else begin
            load_clamp_s = load_val_i;
        end
    end

    // Controller FSM with prescaler and digit register; priority
    // clear > load > stop > start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            presc_r <= PW'(0);
            digit_r <= {DIGIT_W{1'b0}};
        end else if (clear_i) begin
            state_r <= IDLE;
            presc_r <= PW'(0);
            digit_r <= {DIGIT_W{1'b0}};
        end else if (load_i) begin
            presc_r <= PW'(0);
            digit_r <= load_clamp_s;
        end else begin
            case (state_r)
                IDLE: begin
                    presc_r <= PW'(0);
                    if (start_i) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        // Prescaler holds so PAUSE resumes where it left off.
                        state_r <= PAUSE;
                    end else if (at_last_s) begin
                        presc_r <= PW'(0);
                        digit_r <= digit_next_s;
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start_i) begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    presc_r <= PW'(0);
                end
            endcase
        end
    end

    // Output drive: pulses are decodes of the registered state.
    always_comb begin
        tick_o  = tick_s;
        wrap_o  = tick_s && edge_s;
        digit_o = digit_r;
        state_o = state_r;
    end

    seg7_decode u_seg7_decode (
        .digit (digit_r),
        .seg   (seg_o)
    );

endmodule
